// File: rtl/pipe_wb.sv
// ---------------------------------------------------------------------------
// pipe_wb -- writeback stage of the five-stage pipeline.
//
// Holds the MEM/WB pipeline register, aligns and sign/zero-extends load data,
// drives the register-file write port (never writing $0) and counts retired
// instructions for the debug/perf path.
//
// Parameters:
//   DW    datapath width (32 for this core)
//   AW    register-number width
//   CNTW  retired-instruction counter width
//
// Ports:
//   clock, resetn   rising-edge clock, asynchronous active-low reset
//   mvalid..mlsign  MEM-stage instruction fields captured into MEM/WB
//   wstall          hold MEM/WB contents
//   wflush          load a bubble into MEM/WB (wins over wstall)
//   wn, wd, we      register-file write port
//   wvalid          WB holds a real instruction
//   retired         count of instructions that completed WB (wraps)
//
// Optional feature (macro WB_BYPASS_EN):
//   Adds fwd_rn, fwd_data, fwd_en mirroring the write port so the ID stage
//   can read a register in the same cycle it is written.
// ---------------------------------------------------------------------------
module pipe_wb #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CNTW = 32
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            mvalid,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [AW-1:0]   mrn,
    input  logic [DW-1:0]   malu,
    input  logic [DW-1:0]   mmo,
    input  logic [1:0]      mlsize,
    input  logic            mlsign,
    input  logic            wstall,
    input  logic            wflush,
    output logic [AW-1:0]   wn,
    output logic [DW-1:0]   wd,
    output logic            we,
    output logic            wvalid,
`ifdef WB_BYPASS_EN
    output logic [AW-1:0]   fwd_rn,
    output logic [DW-1:0]   fwd_data,
    output logic            fwd_en,
`endif
    output logic [CNTW-1:0] retired
);

    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    // MEM/WB pipeline register fields
    logic            vvalid;
    logic            vwreg;
    logic            vm2reg;
    logic [AW-1:0]   vrn;
    logic [DW-1:0]   valu;
    logic [DW-1:0]   vmo;
    logic [1:0]      vlsize;
    logic            vlsign;
    logic [CNTW-1:0] retired_q;

    // NOTE: every field, data included, is reset; the write port is derived
    // combinationally from these, so a clean reset state keeps wn/wd at 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vvalid <= 1'b0;
            vwreg  <= 1'b0;
            vm2reg <= 1'b0;
            vrn    <= '0;
            valu   <= '0;
            vmo    <= '0;
            vlsize <= '0;
            vlsign <= 1'b0;
        end else if (wflush) begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            vvalid <= 1'b0;
            vwreg  <= 1'b0;
        end else if (!wstall) begin
            vvalid <= mvalid;
            vwreg  <= mwreg;
            vm2reg <= mm2reg;
            vrn    <= mrn;
            valu   <= malu;
            vmo    <= mmo;
            vlsize <= mlsize;
            vlsign <= mlsign;
        end
    end

    // An instruction retires on the edge it leaves WB; a flushed occupant
    // never retires, and a stalled one waits until the stall lifts.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            retired_q <= '0;
        end else if (vvalid && !wstall && !wflush) begin
            retired_q <= retired_q + CNTW'(1);
        end
    end

    // Load alignment from the registered byte address
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        ld_byte = vmo[7:0];
        ld_half = valu[1] ? vmo[31:16] : vmo[15:0];
        ld_data = vmo;
        case (valu[1:0])
            2'd1:    ld_byte = vmo[15:8];
            2'd2:    ld_byte = vmo[23:16];
            2'd3:    ld_byte = vmo[31:24];
            default: ld_byte = vmo[7:0];
        endcase
        case (vlsize)
            LS_BYTE: ld_data = {{(DW-8){vlsign & ld_byte[7]}}, ld_byte};
            LS_HALF: ld_data = {{(DW-16){vlsign & ld_half[15]}}, ld_half};
            default: ld_data = vmo;  // word and reserved encoding
        endcase
    end

    assign wn      = vrn;
    assign wd      = vm2reg ? ld_data : valu;
    assign we      = vvalid & vwreg & (vrn != '0);
    assign wvalid  = vvalid;
    assign retired = retired_q;

`ifdef WB_BYPASS_EN
    assign fwd_rn   = vrn;
    assign fwd_data = wd;
    assign fwd_en   = we & (vrn != '0);
`endif

endmodule

// File: tb/tb_pipe_wb.sv
// ---------------------------------------------------------------------------
// tb_pipe_wb -- self-checking bench for pipe_wb (built with CNTW=4 so the
// retired counter wrap is reachable). Expected write-port values are queued
// when an instruction is driven and popped when it reaches WB.
// ---------------------------------------------------------------------------
module tb_pipe_wb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CNTW = 4;

    logic            clock = 1'b0;
    logic            resetn;
    logic            mvalid, mwreg, mm2reg, mlsign, wstall, wflush;
    logic [AW-1:0]   mrn;
    logic [DW-1:0]   malu, mmo;
    logic [1:0]      mlsize;
    logic [AW-1:0]   wn;
    logic [DW-1:0]   wd;
    logic            we, wvalid;
    logic [CNTW-1:0] retired;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   fwd_rn;
    logic [DW-1:0]   fwd_data;
    logic            fwd_en;
`endif

    pipe_wb #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .mvalid  (mvalid),
        .mwreg   (mwreg),
        .mm2reg  (mm2reg),
        .mrn     (mrn),
        .malu    (malu),
        .mmo     (mmo),
        .mlsize  (mlsize),
        .mlsign  (mlsign),
        .wstall  (wstall),
        .wflush  (wflush),
        .wn      (wn),
        .wd      (wd),
        .we      (we),
        .wvalid  (wvalid),
`ifdef WB_BYPASS_EN
        .fwd_rn  (fwd_rn),
        .fwd_data(fwd_data),
        .fwd_en  (fwd_en),
`endif
        .retired (retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          valid;
        logic          we;
        logic [AW-1:0] rn;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t            sb[$];
    exp_t            cur;
    logic [CNTW-1:0] exp_ret;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive MEM-stage inputs; when push is set, queue the expected WB result.
    task automatic drive(input logic valid, input logic wreg, input logic m2reg,
                         input logic [AW-1:0] rn, input logic [DW-1:0] alu,
                         input logic [DW-1:0] mo, input logic [1:0] lsize,
                         input logic lsign, input logic [DW-1:0] exp_wd,
                         input logic push);
        exp_t e;
        mvalid = valid; mwreg = wreg; mm2reg = m2reg; mrn = rn;
        malu = alu; mmo = mo; mlsize = lsize; mlsign = lsign;
        if (push) begin
            e.valid = valid;
            e.we    = valid & wreg & (rn != 0);
            e.rn    = rn;
            e.wd    = exp_wd;
            sb.push_back(e);
        end
    endtask

    // One clock edge with the given stall/flush, then compare WB outputs.
    task automatic step(input logic stall, input logic flush, input string tag);
        bit flushed;
        wstall = stall;
        wflush = flush;
        @(posedge clock);
        flushed = flush;
        if (cur.valid && !stall && !flush) exp_ret = exp_ret + 1'b1;
        if (flush) begin
            cur.valid = 1'b0;
            cur.we    = 1'b0;
        end else if (!stall) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                cur = sb.pop_front();
            end
        end
        #1;
        check({tag, "_wvalid"},  {31'd0, wvalid}, {31'd0, cur.valid});
        check({tag, "_we"},      {31'd0, we},     {31'd0, cur.we});
        if (!flushed && cur.valid) begin
            check({tag, "_wn"}, {27'd0, wn}, {27'd0, cur.rn});
            check({tag, "_wd"}, wd, cur.wd);
        end
        check({tag, "_retired"}, {28'd0, retired}, {28'd0, exp_ret});
        wstall = 1'b0;
        wflush = 1'b0;
    endtask

    task automatic bubble(input string tag);
        drive(0, 0, 0, '0, '0, '0, 2'b00, 0, '0, 1);
        step(0, 0, tag);
    endtask

    logic [DW-1:0] byte_sx [4];
    logic [DW-1:0] byte_zx [4];
    logic [DW-1:0] held_wd;

    initial begin
        byte_sx = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
        byte_zx = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
        cur = '{valid: 1'b0, we: 1'b0, rn: '0, wd: '0};
        exp_ret = '0;
        wstall = 0; wflush = 0;

        // Reset held with random inputs
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, $urandom_range(0, 1), AW'($urandom), $urandom, $urandom,
                  2'($urandom), $urandom_range(0, 1), '0, 0);
            @(posedge clock);
            #1;
            check("rst_we",      {31'd0, we},      32'd0);
            check("rst_retired", {28'd0, retired}, 32'd0);
        end
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_wn",     {27'd0, wn},     32'd0);
        check("rst_wd",     wd,              32'd0);

        // Release with an ALU writer to r5
        drive(1, 1, 0, 5'd5, 32'h1234, 32'h0, 2'b00, 0, 32'h00001234, 1);
        resetn = 1'b1;
        step(0, 0, "rel");
        bubble("rel_next");

        // Byte loads, sign- then zero-extended
        for (int a = 0; a < 4; a++) begin
            drive(1, 1, 1, 5'd3, 32'h100 | a, 32'h80FF7F01, 2'b10, 1, byte_sx[a], 1);
            step(0, 0, $sformatf("lb_a%0d", a));
        end
        for (int a = 0; a < 4; a++) begin
            drive(1, 1, 1, 5'd4, 32'h200 | a, 32'h80FF7F01, 2'b10, 0, byte_zx[a], 1);
            step(0, 0, $sformatf("lbu_a%0d", a));
        end

        // Halfword loads, low then high half
        drive(1, 1, 1, 5'd6, 32'h300, 32'h8001F00F, 2'b01, 1, 32'hFFFFF00F, 1);
        step(0, 0, "lh_lo");
        drive(1, 1, 1, 5'd6, 32'h302, 32'h8001F00F, 2'b01, 1, 32'hFFFF8001, 1);
        step(0, 0, "lh_hi");
        drive(1, 1, 1, 5'd6, 32'h303, 32'h8001F00F, 2'b01, 0, 32'h00008001, 1);
        step(0, 0, "lhu_odd");

        // Word and reserved sizes pass the memory word through
        drive(1, 1, 1, 5'd7, 32'h401, 32'hCAFEF00D, 2'b00, 1, 32'hCAFEF00D, 1);
        step(0, 0, "lw");
        drive(1, 1, 1, 5'd7, 32'h402, 32'h89ABCDEF, 2'b11, 1, 32'h89ABCDEF, 1);
        step(0, 0, "lrsv");

        // $0 is never written, but still retires
        drive(1, 1, 0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 0, 32'hDEADBEEF, 1);
        step(0, 0, "r0");
        drive(1, 0, 0, 5'd9, 32'h0000ABCD, 32'h0, 2'b00, 0, 32'h0000ABCD, 1);
        step(0, 0, "nowreg");

        // Stall a valid writer for three cycles
        drive(1, 1, 0, 5'd10, 32'h00000055, 32'h0, 2'b00, 0, 32'h00000055, 1);
        step(0, 0, "stl_load");
        held_wd = wd;
        drive(1, 1, 0, 5'd11, 32'h66, 32'h0, 2'b00, 0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, $sformatf("stl%0d", i));
            check("stl_wd_stable", wd, 32'h00000055);
        end
        bubble("stl_rel");

        // Flush and stall together: flush wins, no retirement
        drive(1, 1, 0, 5'd12, 32'h77, 32'h0, 2'b00, 0, 32'h00000077, 1);
        step(0, 0, "fl_load");
        drive(1, 1, 0, 5'd13, 32'h88, 32'h0, 2'b00, 0, '0, 0);
        step(1, 1, "fl_both");
        bubble("fl_after");

        // Counter wrap: reset, 16 retirements bring retired back to 0
        resetn = 1'b0;
        #1;
        cur.valid = 1'b0; cur.we = 1'b0; exp_ret = '0;
        check("wrap_rst", {28'd0, retired}, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 5'(i + 1), 32'(i), 32'h0, 2'b00, 0, 32'(i), 1);
            step(0, 0, $sformatf("wrap%0d", i));
        end
        bubble("wrap_end");
        check("wrap_zero", {28'd0, retired}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_wb.md
Name: pipe_wb

Overview:
Writeback stage of the five-stage pipeline: the write side of the register file that the decode stage reads. Holds the MEM/WB pipeline register and aligns and extends load data. Drives the register-file write port, suppressing writes to $0. Keeps a retired-instruction counter for the debug/perf path.

Parameters:
DW, 32, datapath width (fixed at 32 for this core)
AW, 5, register-number width
CNTW, 32, width of retired-instruction counter

Ports:
clock  in  1  pipeline clock, rising edge
resetn  in  1  asynchronous active-low reset
mvalid  in  1  MEM stage holds a real instruction (0 = bubble)
mwreg  in  1  instruction writes a register
mm2reg  in  1  1 = result comes from memory, 0 = from ALU
mrn  in  AW  destination register number
malu  in  DW  ALU result; low 2 bits are also the load byte address
mmo  in  DW  memory read word, little-endian
mlsize  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
mlsign  in  1  1 = sign-extend sub-word load, 0 = zero-extend
wstall  in  1  hold MEM/WB register contents
wflush  in  1  load a bubble into MEM/WB register
wn  out  AW  regfile write register number
wd  out  DW  regfile write data
we  out  1  regfile write enable
wvalid  out  1  WB holds a real instruction
retired  out  CNTW  count of instructions that completed WB

Behaviour:
- Reset (resetn=0, asynchronous): all MEM/WB register fields are 0, so wvalid=0, we=0, wn=0, wd=0, retired=0. Reset mid-write drops the instruction with no regfile write.
- On rising edge, priority: wflush > wstall > load.
  - wflush=1: vvalid<=0, vwreg<=0; other fields are don't-care but held.
  - wstall=1 (no flush): all fields hold.
  - Otherwise: capture mvalid, mwreg, mm2reg, mrn, malu, mmo, mlsize, mlsign.
- Latency: 1 cycle from MEM inputs to wn/wd/we. wd is combinational from the register contents; no extra cycle.
- Load alignment uses registered malu[1:0]:
  - Byte: select mmo[8*a+7:8*a].
  - Half: select mmo[15:0] when a[1]=0, else mmo[31:16]; a[0] is ignored (unaligned halfword is not trapped here).
  - Word/reserved: mmo unmodified.
  - Extend to DW by sign bit if mlsign=1, else zeros.
- wd = m2reg ? aligned_load : alu.
- we = wvalid & wreg & (wn != 0). $0 is never written even when wreg=1.
- wn = registered rn regardless of we.
- retired increments by 1 on each rising edge where wvalid=1 and wstall=0. Wraps from all-ones to 0 silently.
  - Stall holding a valid instruction counts it once, on the edge it leaves.
  - Flush of a valid WB occupant does not count it.
- Simultaneous wstall and wflush: flush wins; the counter does not increment.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: adds outputs fwd_rn (AW), fwd_data (DW), fwd_en (1), equal to wn, wd, we. The ID stage uses them to read a register in the same cycle it is written (regfile write-through).
- Fwd_en additionally requires fwd_rn != 0.
- Undefined: the ports do not exist. The ID stage relies on the regfile writing at mid-cycle.

Test Plan:
- Reset: hold resetn=0 with random inputs, then release with mvalid=1, mwreg=1, mrn=5, malu=0x1234, mm2reg=0 -> during reset we=0, retired=0; one cycle after release wn=5, wd=0x00001234, we=1, and retired=1 at the next edge.
- Byte load: mmo=0x80FF7F01, mlsize=10, malu[1:0]=0..3, mlsign=1 -> wd = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; with mlsign=0 -> 0x01, 0x7F, 0xFF, 0x80 zero-extended.
- Halfword load: mmo=0x8001F00F, mlsize=01, mlsign=1, malu[1:0]=00 then 10 -> wd = 0xFFFFF00F then 0xFFFF8001.
- $0 suppression: mwreg=1, mrn=0, malu=0xDEADBEEF -> we=0, wn=0, wd=0xDEADBEEF, retired still increments.
- Stall and flush: valid instruction in WB with wstall=1 for 3 cycles -> we stays 1, wd is stable, and retired increments only once after release. Assert wflush=1 and wstall=1 together -> next cycle wvalid=0, we=0, no increment.
- Counter wrap: preload via 2^CNTW-1 retirements (CNTW=4 build) -> after 16 valid instructions retired=0.
